// File: rtl/axi_aw_burst_slave.sv
// AXI write-address slave: queues AW requests in a FIFO and expands INCR bursts into beats.
// Optional AW_BP_RAND_EN adds LFSR-driven pseudo-random awready backpressure.
module axi_aw_burst_slave #(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 4,
    parameter int DEPTH      = 4,
    parameter int BEAT_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_W-1:0]            awid,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic [LEN_W-1:0]           awlen,
    input  logic                       awvalid,
    output logic                       awready,
    output logic                       bt_valid,
    input  logic                       bt_ready,
    output logic [ID_W-1:0]            bt_id,
    output logic [ADDR_W-1:0]          bt_addr,
    output logic [LEN_W-1:0]           bt_idx,
    output logic                       bt_last,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BEAT_BYTES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic              live_q, live_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;

    logic [ID_W-1:0]   id_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];

    logic push;
    logic pop;
    logic not_full;

    assign not_full = (cnt_q != FULL_CNT);

`ifdef AW_BP_RAND_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 8,6,5,4) stepping every cycle
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, reseeded on reset so the stall pattern repeats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign awready = live_q & not_full & lfsr_q[0];
`else
    assign awready = live_q & not_full;
`endif

    assign push     = awvalid & awready;
    assign bt_valid = (state_q == BURST);
    assign bt_id    = id_q;
    assign bt_addr  = addr_q;
    assign bt_idx   = idx_q;
    assign bt_last  = last_q;
    assign fifo_cnt = cnt_q;

    // Burst FSM: load head entry, step beats, chain bursts without a bubble
    always_comb begin
        logic load;
        load     = 1'b0;
        pop      = 1'b0;
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        last_d   = last_q;
        live_d   = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    load    = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (bt_ready) begin
                    if (!last_q) begin
                        idx_d  = idx_q + LEN_W'(1);
                        addr_d = addr_q + STEP;
                        last_d = ((idx_q + LEN_W'(1)) == len_q);
                    end else if (cnt_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop    = 1'b1;
            id_d   = id_mem[rd_ptr_q];
            addr_d = addr_mem[rd_ptr_q];
            len_d  = len_mem[rd_ptr_q];
            idx_d  = '0;
            last_d = (len_mem[rd_ptr_q] == '0);
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control and beat registers; reset drops any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

    // FIFO storage; contents are only meaningful below cnt_q
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q]   <= awid;
            addr_mem[wr_ptr_q] <= awaddr;
            len_mem[wr_ptr_q]  <= awlen;
        end
    end

endmodule

// File: tb/tb_axi_aw_burst_slave.sv
// Directed testbench for axi_aw_burst_slave with hand-computed beat expectations.
// Build with AW_BP_RAND_EN to exercise the random-backpressure variant instead.
module tb_axi_aw_burst_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic        bt_valid;
    logic        bt_ready = 1'b0;
    logic [3:0]  bt_id;
    logic [31:0] bt_addr;
    logic [3:0]  bt_idx;
    logic        bt_last;
    logic [2:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;

    axi_aw_burst_slave dut (
        .clk      (clk),
        .rst      (rst),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awvalid  (awvalid),
        .awready  (awready),
        .bt_valid (bt_valid),
        .bt_ready (bt_ready),
        .bt_id    (bt_id),
        .bt_addr  (bt_addr),
        .bt_idx   (bt_idx),
        .bt_last  (bt_last),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] idx, input logic last);
        check({tag, "_valid"}, 64'(bt_valid), 64'(1));
        check({tag, "_id"}, 64'(bt_id), 64'(id));
        check({tag, "_addr"}, 64'(bt_addr), 64'(addr));
        check({tag, "_idx"}, 64'(bt_idx), 64'(idx));
        check({tag, "_last"}, 64'(bt_last), 64'(last));
        tick();
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        awvalid = 1'b1;
        awid    = id;
        awaddr  = addr;
        awlen   = len;
    endtask

`ifdef AW_BP_RAND_EN
    logic [7:0] model;
    logic       live;
    logic       acc;
    logic [3:0] exp_id;
    int         pushes;
    int         beats;
`endif

    initial begin
`ifdef AW_BP_RAND_EN
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model  = 8'hA5;
        live   = 1'b0;
        pushes = 0;
        beats  = 0;
        exp_id = '0;
        bt_ready = 1'b1;
        req(4'd0, 32'd0, 4'd0);
        for (int c = 0; c < 3000 && (pushes < 100 || beats < 100); c++) begin
            check("aw_rand", 64'(awready), 64'(live & model[0]));
            if (bt_valid) begin
                check("rand_id", 64'(bt_id), 64'(exp_id));
                check("rand_addr", 64'(bt_addr), 64'(beats * 4));
                exp_id = exp_id + 4'd1;
                beats++;
            end
            acc = awvalid & live & model[0];
            @(posedge clk);
            model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
            live  = 1'b1;
            if (acc) pushes++;
            #1;
            if (pushes >= 100) awvalid = 1'b0;
            awid   = 4'(pushes);
            awaddr = 32'(pushes * 4);
        end
        check("rand_pushes", 64'(pushes), 64'(100));
        check("rand_beats", 64'(beats), 64'(100));
`else
        // Reset with awvalid asserted
        req(4'd1, 32'h100, 4'd3);
        tick();
        tick();
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_valid", 64'(bt_valid), 64'(0));
        check("rst_cnt", 64'(fifo_cnt), 64'(0));
        check("rst_last", 64'(bt_last), 64'(0));
        awvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_awready_pre", 64'(awready), 64'(0));
        tick();
        check("rel_awready", 64'(awready), 64'(1));

        // Single burst, 4 beats
        bt_ready = 1'b1;
        req(4'd1, 32'h100, 4'd3);
        tick();
        awvalid = 1'b0;
        check("s_cnt", 64'(fifo_cnt), 64'(1));
        check("s_idle", 64'(bt_valid), 64'(0));
        tick();
        beat("s0", 4'd1, 32'h100, 4'd0, 1'b0);
        beat("s1", 4'd1, 32'h104, 4'd1, 1'b0);
        beat("s2", 4'd1, 32'h108, 4'd2, 1'b0);
        beat("s3", 4'd1, 32'h10C, 4'd3, 1'b1);
        check("s_done", 64'(bt_valid), 64'(0));

        // Fill the FIFO behind a stalled burst
        bt_ready = 1'b0;
        req(4'd1, 32'h200, 4'd0);
        tick();
        req(4'd2, 32'h300, 4'd1);
        tick();
        req(4'd3, 32'h400, 4'd0);
        tick();
        req(4'd4, 32'h500, 4'd2);
        tick();
        req(4'd5, 32'h600, 4'd1);
        tick();
        awvalid = 1'b0;
        check("f_cnt", 64'(fifo_cnt), 64'(4));
        check("f_awready", 64'(awready), 64'(0));
        check("f_id", 64'(bt_id), 64'(1));
        tick();
        check("f_hold_addr", 64'(bt_addr), 64'(32'h200));
        check("f_hold_valid", 64'(bt_valid), 64'(1));
        req(4'd6, 32'h700, 4'd0);
        bt_ready = 1'b1;
        beat("fa", 4'd1, 32'h200, 4'd0, 1'b1);
        awvalid = 1'b0;
        check("f_nopush_full", 64'(fifo_cnt), 64'(3));
        beat("fb0", 4'd2, 32'h300, 4'd0, 1'b0);
        beat("fb1", 4'd2, 32'h304, 4'd1, 1'b1);
        beat("fc", 4'd3, 32'h400, 4'd0, 1'b1);
        beat("fd0", 4'd4, 32'h500, 4'd0, 1'b0);
        beat("fd1", 4'd4, 32'h504, 4'd1, 1'b0);
        beat("fd2", 4'd4, 32'h508, 4'd2, 1'b1);
        beat("fe0", 4'd5, 32'h600, 4'd0, 1'b0);
        beat("fe1", 4'd5, 32'h604, 4'd1, 1'b1);
        check("f_done", 64'(bt_valid), 64'(0));
        check("f_empty", 64'(fifo_cnt), 64'(0));

        // Address wrap plus back-to-back bursts
        req(4'd7, 32'hFFFF_FFF8, 4'd3);
        tick();
        req(4'd8, 32'h40, 4'd0);
        tick();
        awvalid = 1'b0;
        check("w_cnt", 64'(fifo_cnt), 64'(1));
        beat("w0", 4'd7, 32'hFFFF_FFF8, 4'd0, 1'b0);
        beat("w1", 4'd7, 32'hFFFF_FFFC, 4'd1, 1'b0);
        beat("w2", 4'd7, 32'h0000_0000, 4'd2, 1'b0);
        beat("w3", 4'd7, 32'h0000_0004, 4'd3, 1'b1);
        beat("x0", 4'd8, 32'h40, 4'd0, 1'b1);
        check("w_done", 64'(bt_valid), 64'(0));

        // Reset in the middle of a burst
        req(4'd9, 32'h1000, 4'd7);
        tick();
        req(4'd10, 32'h3000, 4'd0);
        tick();
        awvalid = 1'b0;
        beat("y0", 4'd9, 32'h1000, 4'd0, 1'b0);
        beat("y1", 4'd9, 32'h1004, 4'd1, 1'b0);
        check("y2_idx", 64'(bt_idx), 64'(2));
        check("y2_cnt", 64'(fifo_cnt), 64'(1));
        rst = 1'b0;
        #1;
        check("mr_valid", 64'(bt_valid), 64'(0));
        check("mr_cnt", 64'(fifo_cnt), 64'(0));
        check("mr_awready", 64'(awready), 64'(0));
        check("mr_idx", 64'(bt_idx), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        check("mr_live", 64'(awready), 64'(1));
        req(4'd3, 32'h2000, 4'd1);
        tick();
        awvalid = 1'b0;
        check("n_idle", 64'(bt_valid), 64'(0));
        tick();
        beat("n0", 4'd3, 32'h2000, 4'd0, 1'b0);
        beat("n1", 4'd3, 32'h2004, 4'd1, 1'b1);
        check("n_done", 64'(bt_valid), 64'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
